// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter owning the register-file write port: loads win, ALU results
// are buffered in a small FIFO and drained in order, with a pending-register mask.
module regfile_wb_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int REGCOUNT  = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         aluValid,
    output logic                         aluReady,
    input  logic [4:0]                   aluRd,
    input  logic [DATAWIDTH-1:0]         aluData,
    input  logic                         memValid,
    input  logic [4:0]                   memRd,
    input  logic [DATAWIDTH-1:0]         memData,
    output logic                         write,
    output logic [4:0]                   writeReg,
    output logic [DATAWIDTH-1:0]         writeData,
    output logic [REGCOUNT-1:0]          pendingMask,
    output logic [$clog2(DEPTH+1)-1:0]   fifoCount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]           rd_q   [DEPTH];
    logic [4:0]           rd_d   [DEPTH];
    logic [DATAWIDTH-1:0] data_q [DEPTH];
    logic [DATAWIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [AW-1:0]        head_q, head_d;
    logic [AW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 write_q, write_d;
    logic [4:0]           write_reg_q, write_reg_d;
    logic [DATAWIDTH-1:0] write_data_q, write_data_d;
    logic [REGCOUNT-1:0]  pending_s;

    logic alu_ready_s;
    logic push_s;
    logic mem_take_s;
    logic pop_s;

    // Handshake and arbitration decisions, all from pre-edge registered state.
    always_comb begin
        alu_ready_s = (count_q != CW'(DEPTH));
        // x0 results complete the handshake but never occupy a slot.
        push_s      = aluValid && alu_ready_s && (aluRd != 5'd0);
        mem_take_s  = memValid && (memRd != 5'd0);
        pop_s       = !mem_take_s && (count_q != CW'(0));
    end

    // Next-state for FIFO storage, pointers, occupancy and the write stage.
    always_comb begin
        rd_d         = rd_q;
        data_d       = data_q;
        valid_d      = valid_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        write_d      = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;

        if (mem_take_s) begin
            write_d      = 1'b1;
            write_reg_d  = memRd;
            write_data_d = memData;
        end else if (pop_s) begin
            write_d          = 1'b1;
            write_reg_d      = rd_q[head_q];
            write_data_d     = data_q[head_q];
            valid_d[head_q]  = 1'b0;
            head_d           = head_q + AW'(1);
        end else begin
            write_d = 1'b0;
        end

        // Head and tail only coincide when empty or full, so push and pop never share a slot.
        if (push_s) begin
            rd_d[tail_q]    = aluRd;
            data_d[tail_q]  = aluData;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + AW'(1);
        end else begin
            tail_d = tail_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // One-hot OR of destination registers held by valid FIFO entries.
    always_comb begin
        pending_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (int'(rd_q[i]) < REGCOUNT)) begin
                pending_s[rd_q[i]] = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
        pending_s[0] = 1'b0;
    end

    // State registers; reset discards every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= '0;
            end
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            write_q      <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            write_q      <= write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign aluReady    = alu_ready_s;
    assign write       = write_q;
    assign writeReg    = write_reg_q;
    assign writeData   = write_data_q;
    assign pendingMask = pending_s;
    assign fifoCount   = count_q;

    regfile_wb_arbiter_chk #(
        .DEPTH    (DEPTH),
        .REGCOUNT (REGCOUNT),
        .CW       (CW)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .aluReady    (alu_ready_s),
        .pendingMask (pending_s),
        .fifoCount   (count_q)
    );

endmodule

// Invariant checker for the writeback arbiter: occupancy bounds, ready
// consistency and the never-pending x0 register.
module regfile_wb_arbiter_chk #(
    parameter int DEPTH    = 4,
    parameter int REGCOUNT = 32,
    parameter int CW       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                aluReady,
    input  logic [REGCOUNT-1:0] pendingMask,
    input  logic [CW-1:0]       fifoCount
);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifoCount <= CW'(DEPTH));

    a_ready_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        aluReady == (fifoCount != CW'(DEPTH)));

    a_x0_never_pending: assert property (@(posedge clk) disable iff (!rst_n)
        pendingMask[0] == 1'b0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued as stimulus
// is issued and a negedge monitor pops and compares each observed write.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, alu_ready;
    logic [4:0]    alu_rd;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic [4:0]    mem_rd;
    logic [DW-1:0] mem_data;
    logic          write;
    logic [4:0]    write_reg;
    logic [DW-1:0] write_data;
    logic [RC-1:0] pending_mask;
    logic [CW-1:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] sb_q [$];

    regfile_wb_arbiter #(.DATAWIDTH(DW), .REGCOUNT(RC), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aluValid    (alu_valid),
        .aluReady    (alu_ready),
        .aluRd       (alu_rd),
        .aluData     (alu_data),
        .memValid    (mem_valid),
        .memRd       (mem_rd),
        .memData     (mem_data),
        .write       (write),
        .writeReg    (write_reg),
        .writeData   (write_data),
        .pendingMask (pending_mask),
        .fifoCount   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [DW-1:0] d);
        sb_q.push_back({r, d});
    endtask

    // Monitor: every observed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && write === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {27'd0, write_reg, write_data}, 64'd0);
            end else begin
                chk("write_port", {27'd0, write_reg, write_data}, {27'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = '0;

        #2;
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_wreg", 64'(write_reg), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_pending", 64'(pending_mask), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_write", 64'(write), 64'd0);
            chk("idle_ready", 64'(alu_ready), 64'd1);
            chk("idle_count", 64'(fifo_count), 64'd0);
            chk("idle_pending", 64'(pending_mask), 64'd0);
        end

        // Single ALU result.
        expect_wr(5'd5, 32'hDEADBEEF);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        chk("single_pending", 64'(pending_mask), 64'h20);
        chk("single_count", 64'(fifo_count), 64'd1);
        chk("single_nowrite_yet", 64'(write), 64'd0);
        step();
        chk("single_write", 64'(write), 64'd1);
        chk("single_pending_clr", 64'(pending_mask), 64'd0);
        chk("single_count_clr", 64'(fifo_count), 64'd0);
        step();
        chk("single_idle", 64'(write), 64'd0);

        // Load has priority over a buffered ALU result.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        step();
        alu_valid = 1'b0;
        expect_wr(5'd7, 32'h22);
        expect_wr(5'd3, 32'h11);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h22;
        step();
        mem_valid = 1'b0;
        chk("prio_count_held", 64'(fifo_count), 64'd1);
        chk("prio_pending_held", 64'(pending_mask), 64'h8);
        step();
        chk("prio_count_drain", 64'(fifo_count), 64'd0);
        step();

        // Fill under continuous loads, then drain in order.
        for (int i = 0; i < 6; i++) expect_wr(5'd20, 32'h100);
        for (int i = 1; i <= 5; i++) expect_wr(5'(i), 32'h1000 + 32'(i));
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h100;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h1000 + 32'(i);
            step();
        end
        chk("fill_count", 64'(fifo_count), 64'd4);
        chk("fill_ready", 64'(alu_ready), 64'd0);
        alu_rd = 5'd5; alu_data = 32'h1005;
        step();
        step();
        chk("fill_held_count", 64'(fifo_count), 64'd4);
        chk("fill_held_ready", 64'(alu_ready), 64'd0);
        chk("fill_pending", 64'(pending_mask), 64'h1E);
        mem_valid = 1'b0;
        step();
        chk("drain_count_a", 64'(fifo_count), 64'd3);
        chk("drain_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        chk("drain_count_b", 64'(fifo_count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drain_write", 64'(write), 64'd1);
        end
        chk("drain_count_end", 64'(fifo_count), 64'd0);
        step();
        chk("drain_idle", 64'(write), 64'd0);

        // x0 requests are discarded.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("x0_write", 64'(write), 64'd0);
            chk("x0_count", 64'(fifo_count), 64'd0);
            chk("x0_ready", 64'(alu_ready), 64'd1);
        end
        mem_valid = 1'b0;
        alu_rd = 5'd12; alu_data = 32'hC0C0;
        expect_wr(5'd12, 32'hC0C0);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h77;
        step();
        mem_valid = 1'b0;
        chk("x0_mem_pop_write", 64'(write), 64'd1);
        chk("x0_mem_pop_count", 64'(fifo_count), 64'd0);
        step();

        // Steady-state streaming across pointer wrap.
        for (int k = 0; k < 12; k++) expect_wr(5'(16 + k), 32'hA5000000 + 32'(k));
        for (int k = 0; k < 12; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(16 + k); alu_data = 32'hA5000000 + 32'(k);
            step();
            chk("stream_count", 64'(fifo_count), 64'd1);
        end
        alu_valid = 1'b0;
        step();
        chk("stream_count_end", 64'(fifo_count), 64'd0);

        // WAW on x9: last write must carry the later value.
        expect_wr(5'd9, 32'hA);
        expect_wr(5'd9, 32'hB);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA;
        step();
        alu_data = 32'hB;
        step();
        alu_valid = 1'b0;
        chk("waw_pending", 64'(pending_mask), 64'h200);
        step();
        chk("waw_last_data", 64'(write_data), 64'hB);
        chk("waw_pending_clr", 64'(pending_mask), 64'd0);
        step();

        // Asynchronous reset with three entries buffered.
        for (int i = 0; i < 3; i++) expect_wr(5'd30, 32'h300);
        mem_valid = 1'b1; mem_rd = 5'd30; mem_data = 32'h300;
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h2000 + 32'(i);
            step();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("prerst_count", 64'(fifo_count), 64'd3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_write", 64'(write), 64'd0);
        chk("midrst_wreg", 64'(write_reg), 64'd0);
        chk("midrst_wdata", 64'(write_data), 64'd0);
        chk("midrst_count", 64'(fifo_count), 64'd0);
        chk("midrst_pending", 64'(pending_mask), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("postrst_write", 64'(write), 64'd0);
            chk("postrst_count", 64'(fifo_count), 64'd0);
        end

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
